win_scoreboard: RTL

- Downstream of the light chain. Consumes the end-light states (LEDR[9], LEDR[1]) and the conditioned player press pulses.
- Detects round wins and keeps per-player round scores. Drives HEX5 (left score) and HEX0 (right score).
- Issues a timed one-cycle restartGame pulse to the light modules after each round.
- Latches match-over when a player reaches WIN_ROUNDS.

---
 rtl/tow_pkg.sv | 22 ++
 rtl/win_scoreboard_if.sv | 28 ++
 rtl/win_scoreboard_seg7_digit.sv | 25 ++
 rtl/win_scoreboard.sv | 121 ++++++++++++
 4 files changed

// File: rtl/tow_pkg.sv
// Shared types and constants for the tug-of-war round scoreboard.
package tow_pkg;

  typedef enum logic [1:0] {
    PLAY       = 2'd0,
    HOLD       = 2'd1,
    RESTART    = 2'd2,
    MATCH_OVER = 2'd3
  } state_t;

  // Active-low seven-segment patterns, bit order gfedcba.
  localparam logic [6:0] SEG_BLANK   = 7'b1111111;
  localparam logic [6:0] SEG_DIGIT_0 = 7'b1000000;
  localparam logic [6:0] SEG_DIGIT_1 = 7'b1111001;
  localparam logic [6:0] SEG_DIGIT_2 = 7'b0100100;
  localparam logic [6:0] SEG_DIGIT_3 = 7'b0110000;
  localparam logic [6:0] SEG_DIGIT_4 = 7'b0011001;
  localparam logic [6:0] SEG_DIGIT_5 = 7'b0010010;
  localparam logic [6:0] SEG_DIGIT_6 = 7'b0000010;
  localparam logic [6:0] SEG_DIGIT_7 = 7'b1111000;

endpackage

// File: rtl/win_scoreboard_if.sv
// Player/light inputs and score/display outputs of the scoreboard.
interface win_scoreboard_if;
  logic       L;
  logic       R;
  logic       LED9;
  logic       LED1;
  logic       restartGame;
  logic [6:0] HEX5;
  logic [6:0] HEX0;
  logic [2:0] left_score;
  logic [2:0] right_score;
  logic       match_over;
  logic       left_won_last;

  // Upstream side: drives presses and end-light states, observes results.
  modport master (
    output L, R, LED9, LED1,
    input  restartGame, HEX5, HEX0, left_score, right_score,
           match_over, left_won_last
  );

  // Scoreboard side.
  modport slave (
    input  L, R, LED9, LED1,
    output restartGame, HEX5, HEX0, left_score, right_score,
           match_over, left_won_last
  );
endinterface

// File: rtl/win_scoreboard_seg7_digit.sv
// Converts a 3-bit value (0..7) to active-low seven-segment pattern.
module seg7_digit
  import tow_pkg::*;
(
  input  logic [2:0] value,
  output logic [6:0] seg
);

  // Pure lookup of the digit glyph.
  always_comb begin
    seg = SEG_BLANK;
    case (value)
      3'd0: seg = SEG_DIGIT_0;
      3'd1: seg = SEG_DIGIT_1;
      3'd2: seg = SEG_DIGIT_2;
      3'd3: seg = SEG_DIGIT_3;
      3'd4: seg = SEG_DIGIT_4;
      3'd5: seg = SEG_DIGIT_5;
      3'd6: seg = SEG_DIGIT_6;
      3'd7: seg = SEG_DIGIT_7;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/win_scoreboard.sv
// Round-win detection, per-player scores, timed restart pulse and
// match-over latch for the tug-of-war game.
module win_scoreboard
  import tow_pkg::*;
#(
  parameter int unsigned WIN_ROUNDS  = 7,
  parameter int unsigned HOLD_CYCLES = 1526
) (
  input  logic               Clock,
  input  logic               Reset,
  win_scoreboard_if.slave    bus
);

  localparam int unsigned CW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [2:0]    WIN_CNT   = 3'(WIN_ROUNDS);

  state_t        state, state_next;
  logic [CW-1:0] hold_cnt, hold_cnt_next;
  logic [2:0]    left_score, left_score_next;
  logic [2:0]    right_score, right_score_next;
  logic          left_won_last, left_won_last_next;

  logic left_win;
  logic right_win;
  logic [2:0] left_inc;
  logic [2:0] right_inc;

  // Win events; a simultaneous press never counts, nor do two wins at once.
  always_comb begin
    left_win  = bus.LED9 & bus.L & ~bus.R;
    right_win = bus.LED1 & bus.R & ~bus.L;
    left_inc  = left_score + 3'd1;
    right_inc = right_score + 3'd1;
  end

  // State, counter and score registers with synchronous active-low reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state         <= PLAY;
      hold_cnt      <= '0;
      left_score    <= '0;
      right_score   <= '0;
      left_won_last <= 1'b0;
    end else begin
      state         <= state_next;
      hold_cnt      <= hold_cnt_next;
      left_score    <= left_score_next;
      right_score   <= right_score_next;
      left_won_last <= left_won_last_next;
    end
  end

  // Next-state logic: score a round, hold the result, pulse restart.
  always_comb begin
    state_next         = state;
    hold_cnt_next      = hold_cnt;
    left_score_next    = left_score;
    right_score_next   = right_score;
    left_won_last_next = left_won_last;
    case (state)
      PLAY: begin
        if (left_win && !right_win) begin
          left_score_next    = left_inc;
          left_won_last_next = 1'b1;
          if (left_inc == WIN_CNT) begin
            state_next = MATCH_OVER;
          end else begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
          end
        end else if (right_win && !left_win) begin
          right_score_next   = right_inc;
          left_won_last_next = 1'b0;
          if (right_inc == WIN_CNT) begin
            state_next = MATCH_OVER;
          end else begin
            state_next    = HOLD;
            hold_cnt_next = HOLD_LOAD;
          end
        end
      end
      HOLD: begin
        if (hold_cnt == '0) begin
          state_next = RESTART;
        end else begin
          hold_cnt_next = hold_cnt - 1'b1;
        end
      end
      RESTART: begin
        state_next = PLAY;
      end
      MATCH_OVER: begin
        state_next = MATCH_OVER;
      end
      default: begin
        state_next = PLAY;
      end
    endcase
  end

  // Outputs decoded from registered state, so restartGame is glitch-free.
  always_comb begin
    bus.restartGame   = (state == RESTART);
    bus.match_over    = (state == MATCH_OVER);
    bus.left_score    = left_score;
    bus.right_score   = right_score;
    bus.left_won_last = left_won_last;
  end

  seg7_digit u_left_digit (
    .value (left_score),
    .seg   (bus.HEX5)
  );

  seg7_digit u_right_digit (
    .value (right_score),
    .seg   (bus.HEX0)
  );

endmodule
